fsk_tx_framer: RTL and testbench

Parametrised UART-style framer for the FSK modulator path. It accepts words from the UART RX side over a valid/ready handshake and buffers them in a small FIFO. It serialises each word as start, data (LSB first), optional parity and 1–2 stop symbols. Every symbol is held exactly SYMBOL_PERIOD clocks, and bit_out drives the FSK tone selector.

---
 rtl/fsk_tx_framer.sv | 202 ++++++++++++++++++++
 tb/tb_fsk_tx_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fsk_tx_framer.sv
// fsk_tx_framer: UART-style serial framer feeding the FSK tone selector.
// Words arrive over a valid/ready handshake into a small FIFO. Each word is
// sent as start (0), DATA_BITS data symbols LSB first, an optional parity
// symbol and STOP_BITS stop symbols (1). Every symbol lasts SYMBOL_PERIOD clocks.
//
// Optional feature: define FSK_TX_PARITY_EN to insert a parity symbol after
// the data (even parity, inverted when PARITY_ODD = 1).
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   in_valid_i      in_data_i valid this cycle
//   in_data_i       word to transmit
//   in_ready_o      FIFO can accept (write on in_valid_i && in_ready_o)
//   bit_out_o       serial symbol stream
//   sending_o       high while any frame symbol is on bit_out_o
//   symbol_strobe_o one-cycle pulse on the first clock of each symbol
//   fifo_count_o    queued words, excluding the frame in flight
module fsk_tx_framer #(
  parameter int SYMBOL_PERIOD = 434,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter bit IDLE_LEVEL    = 1'b0,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  input  logic [DATA_BITS-1:0]          in_data_i,
  output logic                          in_ready_o,
  output logic                          bit_out_o,
  output logic                          sending_o,
  output logic                          symbol_strobe_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(SYMBOL_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(SYMBOL_PERIOD - 1);
  localparam logic [3:0]    D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    S_LAST = 4'(STOP_BITS - 1);

`ifdef FSK_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign in_ready_o   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count_o = count_q;
  assign push         = in_valid_i && in_ready_o;
  assign head         = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the read is registered by
  // the shift register load below.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= in_data_i;
  end

  // ---------------- FSM ----------------
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
`ifdef FSK_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef FSK_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
`ifdef FSK_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic
  logic load;
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef FSK_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    load = 1'b0;
    pop  = 1'b0;

    if (state_q == S_IDLE) begin
      timer_d = '0;
      load    = (count_q != '0);
    end else if (timer_q != T_LAST) begin
      timer_d = timer_q + TW'(1);
    end else begin
      // Symbol boundary: move to the next symbol on this edge.
      timer_d   = '0;
      bit_cnt_d = '0;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q != D_LAST) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
`ifdef FSK_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef FSK_TX_PARITY_EN
        S_PARITY: state_d = S_STOP;
`endif
        S_STOP: begin
          if (bit_cnt_q != S_LAST) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (count_q != '0) begin
            load = 1'b1;  // back-to-back frame, no idle gap
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (load) begin
      pop       = 1'b1;
      state_d   = S_START;
      shift_d   = head;
      timer_d   = '0;
      bit_cnt_d = '0;
`ifdef FSK_TX_PARITY_EN
      parity_d  = (^head) ^ PARITY_ODD;
`endif
    end
  end

  // Output logic
  always_comb begin
    bit_out_o = IDLE_LEVEL;
    case (state_q)
      S_START:  bit_out_o = 1'b0;
      S_DATA:   bit_out_o = shift_q[0];
`ifdef FSK_TX_PARITY_EN
      S_PARITY: bit_out_o = parity_q;
`endif
      S_STOP:   bit_out_o = 1'b1;
      default:  bit_out_o = IDLE_LEVEL;
    endcase
    sending_o       = (state_q != S_IDLE);
    // The timer restarts at zero on every symbol change, including frame chaining.
    symbol_strobe_o = (state_q != S_IDLE) && (timer_q == '0);
  end

endmodule

// File: tb/tb_fsk_tx_framer.sv
module tb_fsk_tx_framer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, bit_out, sending, strobe;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsk_tx_framer #(
    .SYMBOL_PERIOD(4), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(4), .IDLE_LEVEL(1'b0), .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .bit_out_o(bit_out), .sending_o(sending),
    .symbol_strobe_o(strobe), .fifo_count_o(fifo_count)
  );

`ifdef FSK_TX_PARITY_EN
  logic       in_valid_p;
  logic [6:0] in_data_p;
  logic       rdy_e, bit_e, snd_e, stb_e, rdy_o, bit_o, snd_o, stb_o;
  logic [2:0] cnt_e, cnt_o;

  fsk_tx_framer #(
    .SYMBOL_PERIOD(4), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(4), .IDLE_LEVEL(1'b0), .PARITY_ODD(1'b0)
  ) dut_even (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_p), .in_data_i(in_data_p),
    .in_ready_o(rdy_e), .bit_out_o(bit_e), .sending_o(snd_e),
    .symbol_strobe_o(stb_e), .fifo_count_o(cnt_e)
  );

  fsk_tx_framer #(
    .SYMBOL_PERIOD(4), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(4), .IDLE_LEVEL(1'b0), .PARITY_ODD(1'b1)
  ) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_p), .in_data_i(in_data_p),
    .in_ready_o(rdy_o), .bit_out_o(bit_o), .sending_o(snd_o),
    .symbol_strobe_o(stb_o), .fifo_count_o(cnt_o)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one 8N1 frame (SP=4, 40 clocks) from frame cycle 'first' onward,
  // leaving the bench one clock past the frame's last cycle.
  task automatic frame(input logic [7:0] d, input int first);
    int  sym;
    logic expb;
    for (int i = first; i < 40; i++) begin
      sym  = i / 4;
      if (sym == 0)      expb = 1'b0;
      else if (sym <= 8) expb = d[sym-1];
      else               expb = 1'b1;
      chk($sformatf("bit_out d=%0h cyc=%0d", d, i), bit_out, expb);
      chk($sformatf("sending d=%0h cyc=%0d", d, i), sending, 1);
      chk($sformatf("strobe d=%0h cyc=%0d", d, i), strobe, (i % 4 == 0));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef FSK_TX_PARITY_EN
    in_valid_p = 1'b0; in_data_p = 7'h00;
`endif
    tick(); tick();

    // Reset state
    chk("rst bit_out", bit_out, 0);
    chk("rst sending", sending, 0);
    chk("rst strobe", strobe, 0);
    chk("rst count", fifo_count, 0);
    chk("rst in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    $display("step: reset done");

    // Single frame 0xA5
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("a5 count after write", fifo_count, 1);
    chk("a5 idle before start", sending, 0);
    tick();
    chk("a5 popped count", fifo_count, 0);
    frame(8'hA5, 0);
    chk("a5 end sending", sending, 0);
    chk("a5 end bit_out", bit_out, 0);
    $display("step: frame A5 checked");

    // Three back-to-back frames
    in_valid = 1'b1; in_data = 8'h01;
    tick();
    chk("b2b count w1", fifo_count, 1);
    in_data = 8'h02;
    tick();
    chk("b2b count w2", fifo_count, 1);
    chk("b2b started", sending, 1);
    in_data = 8'h03;
    tick();
    chk("b2b count peak", fifo_count, 2);
    in_valid = 1'b0;
    frame(8'h01, 1);
    frame(8'h02, 0);
    frame(8'h03, 0);
    chk("b2b end sending", sending, 0);
    chk("b2b end count", fifo_count, 0);
    $display("step: frames 01 02 03 checked");

    // FIFO full with in_valid held
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    in_data = 8'h11; tick();
    in_data = 8'h12; tick();
    in_data = 8'h13; tick();
    in_data = 8'h14; tick();
    in_data = 8'h15;
    for (int c = 3; c < 40; c++) begin
      chk($sformatf("full count cyc=%0d", c), fifo_count, 4);
      chk($sformatf("full ready cyc=%0d", c), in_ready, 0);
      tick();
    end
    chk("full pop count", fifo_count, 3);
    chk("full pop ready", in_ready, 1);
    chk("full pop strobe", strobe, 1);
    tick();
    chk("full one write", fifo_count, 4);
    in_valid = 1'b0;
    frame(8'h11, 1);
    frame(8'h12, 0);
    frame(8'h13, 0);
    frame(8'h14, 0);
    frame(8'h15, 0);
    chk("full end sending", sending, 0);
    chk("full end count", fifo_count, 0);
    $display("step: full FIFO sequence checked");

    // Reset during DATA with two words queued
    in_valid = 1'b1; in_data = 8'h20; tick();
    in_data = 8'h21; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid pre-reset count", fifo_count, 2);
    chk("mid pre-reset sending", sending, 1);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    tick();
    chk("mid rst bit_out", bit_out, 0);
    chk("mid rst sending", sending, 0);
    chk("mid rst count", fifo_count, 0);
    chk("mid rst ready", in_ready, 1);
    in_valid = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c % 10 == 0) chk($sformatf("post-rst quiet cyc=%0d", c), sending, 0);
      tick();
    end
    $display("step: mid-frame reset checked");

`ifdef FSK_TX_PARITY_EN
    begin
      logic [10:0] exp_even, exp_odd;
      exp_even = 11'b110_1000_0010;  // symbols LSB first: 0,1,0,0,0,0,0,1,0,1,1
      exp_odd  = 11'b111_1000_0010;  // parity symbol (index 8) is 1
      in_valid_p = 1'b1; in_data_p = 7'h41;
      tick();
      in_valid_p = 1'b0;
      tick();
      for (int i = 0; i < 44; i++) begin
        chk($sformatf("par even cyc=%0d", i), bit_e, exp_even[i/4]);
        chk($sformatf("par odd cyc=%0d", i), bit_o, exp_odd[i/4]);
        chk($sformatf("par sending cyc=%0d", i), snd_e, 1);
        tick();
      end
      chk("par end sending", snd_e, 0);
      $display("step: parity frames checked");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
